// File: rtl/iic_bit_sequencer.sv
// Bit-level I2C line sequencer: runs START/STOP/WRITE/READ primitives as four quarter-SCL phases.
// Optional slave clock stretching in phase 1 is enabled by defining IIC_CLK_STRETCH_EN.
module iic_bit_sequencer #(
    parameter int DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic       cmd_wdata,
    output logic       cmd_ready,
    output logic       done,
    output logic       rd_bit,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_READ  = 2'b11
    } cmd_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    cmd_t          cmd_q;
    logic          wdata_q;
    logic          rd_bit_q;
    logic          scl_hold, sda_hold;
    logic          scl_dec, sda_dec;
    logic          stall;
    logic          tick;

`ifdef IIC_CLK_STRETCH_EN
    // A slave holding SCL low while we release it in phase 1 freezes the quarter-period count.
    assign stall = (phase_q == 2'd1) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall         = 1'b0;
`endif

    assign tick      = (state_q == ACTIVE) && en && !stall && (cnt_q == CW'(DIV - 1));
    assign done      = tick && (phase_q == 2'd3);
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == ACTIVE);
    assign rd_bit    = rd_bit_q;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    phase_d = '0;
                end
            end
            ACTIVE: begin
                if (en && !stall) begin
                    if (tick) begin
                        cnt_d = '0;
                        if (phase_q == 2'd3) begin
                            state_d = IDLE;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_dec = 1'b0;
        sda_dec = 1'b0;
        case (cmd_q)
            CMD_START: begin
                sda_dec = (phase_q != 2'd0);
                scl_dec = (phase_q == 2'd3);
            end
            CMD_STOP: begin
                sda_dec = (phase_q <= 2'd1);
                scl_dec = (phase_q == 2'd0);
            end
            CMD_WRITE: begin
                sda_dec = ~wdata_q;
                scl_dec = (phase_q == 2'd0) || (phase_q == 2'd3);
            end
            CMD_READ: begin
                sda_dec = 1'b0;
                scl_dec = (phase_q == 2'd0) || (phase_q == 2'd3);
            end
            default: ;
        endcase
    end

    // In IDLE the lines keep whatever the last command left on them in its final phase.
    assign scl_oe = (state_q == ACTIVE) ? scl_dec : scl_hold;
    assign sda_oe = (state_q == ACTIVE) ? sda_dec : sda_hold;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            cmd_q    <= CMD_START;
            wdata_q  <= 1'b0;
            rd_bit_q <= 1'b0;
            scl_hold <= 1'b0;
            sda_hold <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            if (cmd_valid && (state_q == IDLE)) begin
                cmd_q   <= cmd_t'(cmd);
                wdata_q <= cmd_wdata;
            end
            if (state_q == ACTIVE) begin
                scl_hold <= scl_dec;
                sda_hold <= sda_dec;
            end
            if (tick && (phase_q == 2'd1) && (cmd_q == CMD_READ)) begin
                rd_bit_q <= sda_in;
            end
        end
    end

endmodule

// File: tb/tb_iic_bit_sequencer.sv
// Directed self-checking bench for iic_bit_sequencer with DIV=4; expected cycle timings are hand-derived.
// Compile with IIC_CLK_STRETCH_EN defined to check the stretched READ completion time.
module tb_iic_bit_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_wdata;
    logic       cmd_ready;
    logic       done;
    logic       rd_bit;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    int compared   = 0;
    int mismatched = 0;

    iic_bit_sequencer #(.DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_wdata (cmd_wdata),
        .cmd_ready (cmd_ready),
        .done      (done),
        .rd_bit    (rd_bit),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents a command for one cycle (cycle t); returns at the sample point of cycle t+1.
    task automatic issue(input logic [1:0] c, input logic w);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_wdata = w;
        step();
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        cmd_wdata = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic exp_scl, input logic exp_sda);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_scl"},   32'(scl_oe),    32'(exp_scl));
        check({tag, "_sda"},   32'(sda_oe),    32'(exp_sda));
    endtask

    int stretch_done;

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        cmd_wdata = 1'b0;
        scl_in    = 1'b1;
        sda_in    = 1'b1;
`ifdef IIC_CLK_STRETCH_EN
        stretch_done = 21;
`else
        stretch_done = 16;
`endif

        // 1. Reset values, then reset in the middle of a WRITE.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_bit", 32'(rd_bit), 32'd0);
        check_idle("rst", 1'b0, 1'b0);

        issue(2'b10, 1'b0);
        for (int n = 1; n < 10; n++) step();
        check("midw_busy", 32'(busy), 32'd1);
        check("midw_sda", 32'(sda_oe), 32'd1);
        check("midw_scl", 32'(scl_oe), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_rd_bit", 32'(rd_bit), 32'd0);
        check_idle("abort", 1'b0, 1'b0);
        step();
        check("abort_done2", 32'(done), 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            check($sformatf("abort_quiet@%0d", n), 32'(done), 32'd0);
            step();
        end

        // 2. START.
        issue(2'b00, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            check($sformatf("start_sda@%0d", n), 32'(sda_oe), 32'(n >= 5));
            check($sformatf("start_scl@%0d", n), 32'(scl_oe), 32'(n >= 13));
            check($sformatf("start_done@%0d", n), 32'(done), 32'(n == 16));
            check($sformatf("start_ready@%0d", n), 32'(cmd_ready), 32'd0);
            step();
        end
        check_idle("start_idle", 1'b1, 1'b1);
        step();
        check_idle("start_idle2", 1'b1, 1'b1);

        // 3. WRITE 0 with an ignored request at t+8.
        issue(2'b10, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            check($sformatf("wr0_sda@%0d", n), 32'(sda_oe), 32'd1);
            check($sformatf("wr0_scl@%0d", n), 32'(scl_oe), 32'((n <= 4) || (n >= 13)));
            check($sformatf("wr0_done@%0d", n), 32'(done), 32'(n == 16));
            check($sformatf("wr0_busy@%0d", n), 32'(busy), 32'd1);
            if (n == 8) begin
                cmd_valid = 1'b1;
                cmd       = 2'b11;
            end
            if (n == 9) begin
                cmd_valid = 1'b0;
                cmd       = 2'b00;
            end
            step();
        end
        check_idle("wr0_idle", 1'b1, 1'b1);

        // 4. READ sampling a 1, then a 0.
        sda_in = 1'b1;
        issue(2'b11, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            check($sformatf("rd1_sda@%0d", n), 32'(sda_oe), 32'd0);
            check($sformatf("rd1_bit@%0d", n), 32'(rd_bit), 32'(n >= 9));
            check($sformatf("rd1_done@%0d", n), 32'(done), 32'(n == 16));
            step();
        end
        check_idle("rd1_idle", 1'b1, 1'b0);
        sda_in = 1'b0;
        issue(2'b11, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            check($sformatf("rd0_bit@%0d", n), 32'(rd_bit), 32'(n < 9));
            check($sformatf("rd0_done@%0d", n), 32'(done), 32'(n == 16));
            step();
        end
        check("rd0_hold", 32'(rd_bit), 32'd0);

        // 5. WRITE 1 with en low for cycles t+10..t+12, then STOP.
        issue(2'b10, 1'b1);
        for (int n = 1; n <= 19; n++) begin
            check($sformatf("gap_sda@%0d", n), 32'(sda_oe), 32'd0);
            check($sformatf("gap_scl@%0d", n), 32'(scl_oe), 32'((n <= 4) || (n >= 16)));
            check($sformatf("gap_done@%0d", n), 32'(done), 32'(n == 19));
            if (n == 10) en = 1'b0;
            if (n == 13) en = 1'b1;
            step();
        end
        check_idle("gap_idle", 1'b1, 1'b0);
        issue(2'b01, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            check($sformatf("stop_sda@%0d", n), 32'(sda_oe), 32'(n <= 8));
            check($sformatf("stop_scl@%0d", n), 32'(scl_oe), 32'(n <= 4));
            check($sformatf("stop_done@%0d", n), 32'(done), 32'(n == 16));
            step();
        end
        check_idle("stop_idle", 1'b0, 1'b0);

        // 6. READ with SCL held low for the first five cycles of phase 1.
        sda_in = 1'b1;
        issue(2'b11, 1'b0);
        for (int n = 1; n <= 21; n++) begin
            check($sformatf("str_done@%0d", n), 32'(done), 32'(n == stretch_done));
            check($sformatf("str_busy@%0d", n), 32'(busy), 32'(n <= stretch_done));
            if (n == 5)  scl_in = 1'b0;
            if (n == 10) scl_in = 1'b1;
            step();
        end
        check("str_rd_bit", 32'(rd_bit), 32'd1);
        check_idle("str_idle", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/iic_bit_sequencer.md
Name: iic_bit_sequencer

Overview:
- Bit-level I2C line sequencer for the APDAQ IIC subsystem.
- Owns the SCL quarter-period divider counter: an `en`-gated 0..DIV-1 counter with terminal-count tick.
- Executes one bus primitive per command (START, STOP, WRITE bit, READ bit) as four quarter-period phases.
- Drives the open-drain output enables; a byte-level IIC master issues commands to it through a valid/ready handshake.

Parameters:
- DIV, 64, system clocks per quarter SCL period; legal range DIV >= 2; counter width $clog2(DIV).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  global clock-enable; when low, divider and phase freeze
- cmd_valid  in  1  command request
- cmd  in  2  00 START, 01 STOP, 10 WRITE, 11 READ
- cmd_wdata  in  1  bit to transmit for WRITE; ignored otherwise
- cmd_ready  out  1  high when a command can be accepted
- done  out  1  one-cycle pulse at command completion
- rd_bit  out  1  last sampled READ bit
- busy  out  1  command in progress
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- scl_in  in  1  SCL line level, already synchronised to clk
- sda_in  in  1  SDA line level, already synchronised to clk

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, phase=0.
  - scl_oe=0, sda_oe=0, rd_bit=0, done=0.
  - cmd_ready=1, busy=0.
- States: IDLE, ACTIVE.
  - cmd_ready = (state==IDLE); busy = (state==ACTIVE).
- Accept in cycle t when cmd_valid && cmd_ready, independent of `en`.
  - Latch cmd and cmd_wdata, go ACTIVE, cnt=0, phase=0.
- Divider and phase advance:
  - In ACTIVE with en=1: cnt increments; tick = en && cnt==DIV-1, and on tick cnt wraps to 0.
  - Tick in phases 0-2: phase increments.
  - Tick in phase 3: done=1 that cycle, state returns to IDLE, cmd_ready=1 next cycle.
  - With `en` held high, phase p occupies cycles t+1+p*DIV .. t+(p+1)*DIV, and done fires at t+4*DIV.
  - en=0 freezes cnt and phase; no tick and no done while low.
- Line enables in ACTIVE, listed as phase0..3, decoded from latched cmd and phase:
  - START: sda_oe 0,1,1,1; scl_oe 0,0,0,1
  - STOP: sda_oe 1,1,0,0; scl_oe 1,0,0,0
  - WRITE: sda_oe = ~wdata in all phases; scl_oe 1,0,0,1
  - READ: sda_oe 0 in all phases; scl_oe 1,0,0,1
- READ sampling: sda_in is sampled on the tick ending phase 1 and appears on rd_bit the next cycle. rd_bit holds until the next READ sample or reset.
- In IDLE, scl_oe and sda_oe hold the phase-3 values of the last command.
  - After STOP, both are 0 (bus free).
  - After reset with no commands, both are 0.
- cmd_valid while busy is ignored; the command is not latched.
- Reset mid-command aborts immediately: lines released, no done pulse.
- No back-to-back overlap: minimum spacing between dones is 4*DIV+1 cycles.

Optional Feature:
- Macro: IIC_CLK_STRETCH_EN.
- With the macro defined, slave clock stretching is honoured:
  - In phase 1 (SCL released), while scl_in==0, cnt holds at 0 and does not advance.
  - Phase 1 timing restarts counting only after scl_in reads 1.
  - Completion is delayed by exactly the number of phase-1 cycles with scl_in==0 (en=1).
- Without the macro, scl_in is unused and timing is fixed at 4*DIV enabled cycles.

Test Plan (DIV=4 unless stated):
1. Assert rst, release -> scl_oe=0, sda_oe=0, rd_bit=0, done=0, cmd_ready=1, busy=0. Assert rst again mid-WRITE (phase 2) -> same values on the next sample, no done.
2. START accepted at t, en=1 ->
   - sda_oe=1 from t+5.
   - scl_oe=1 from t+13.
   - done only at t+16; cmd_ready=1 at t+17.
   - Lines hold sda_oe=1, scl_oe=1 in IDLE.
3. WRITE wdata=0 at t -> sda_oe=1 for t+1..t+16. scl_oe=1 at t+1..t+4, 0 at t+5..t+12, 1 at t+13..t+16. done at t+16. A cmd_valid pulse at t+8 is not accepted.
4. READ at t with sda_in=1 during phase 1 -> sda_oe=0 throughout, rd_bit=1 from t+9, done at t+16. Repeat with sda_in=0 -> rd_bit=0.
5. WRITE at t with en=0 for 3 cycles inside phase 2 -> phase/cnt frozen during the gap, done at t+19. Then STOP -> both oe=0 after done.
6. IIC_CLK_STRETCH_EN defined, READ at t, scl_in=0 for 5 cycles at the start of phase 1 -> done at t+21. Macro undefined, same stimulus -> done at t+16.
